// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/writeback sequencer in front of a combinational ALU.
// S1 holds one decoded instruction and drives the ALU. The ALU answer is
// captured into a 2-entry in-order output queue that the consumer drains.
module alu_issue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_ctr,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_is_br,
  output logic        out_taken,
  output logic        out_is_mem,
  output logic        out_illegal
);

  localparam logic [3:0] CTR_AND  = 4'b0000;
  localparam logic [3:0] CTR_OR   = 4'b0001;
  localparam logic [3:0] CTR_ADD  = 4'b0010;
  localparam logic [3:0] CTR_SUB  = 4'b0011;
  localparam logic [3:0] CTR_SLT  = 4'b1010;
  localparam logic [3:0] CTR_SHL  = 4'b1000;
  localparam logic [3:0] CTR_SHR  = 4'b1001;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;

  localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

  // queue entry: {result, rd, wen, is_br, taken, is_mem, illegal}
  localparam int ENTRY_W = 42;

  // ---------------------------------------------------------------- decode
  logic [3:0]  dec_ctr;
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic [4:0]  dec_shamt;
  logic        dec_wen;
  logic        dec_is_br;
  logic        dec_br_ne;
  logic        dec_is_mem;
  logic        dec_illegal;
  logic        dec_is_r;
  logic [31:0] dec_src2;
  logic [4:0]  dec_sh_src;
  logic        dec_sh_bad;

  // Translate the incoming instruction into ALU controls and outcome flags.
  always_comb begin
    dec_ctr     = CTR_AND;
    dec_op1     = '0;
    dec_op2     = '0;
    dec_shamt   = '0;
    dec_wen     = 1'b0;
    dec_is_br   = 1'b0;
    dec_br_ne   = 1'b0;
    dec_is_mem  = 1'b0;
    dec_illegal = 1'b0;
    dec_is_r    = (in_opcode == OPC_R);
    dec_src2    = dec_is_r ? in_rs2 : in_imm;
    dec_sh_src  = dec_is_r ? in_rs2[4:0] : in_imm[4:0];
    // R-type shifts require funct7 bit 5 clear, I-type shifts imm[10] clear
    dec_sh_bad  = dec_is_r ? in_funct7b5 : in_imm[10];
    case (in_opcode)
      OPC_R, OPC_I: begin
        dec_op1 = in_rs1;
        dec_op2 = dec_src2;
        dec_wen = (in_rd != 5'd0);
        case (in_funct3)
          3'b000: dec_ctr = (dec_is_r && in_funct7b5) ? CTR_SUB : CTR_ADD;
          3'b111: dec_ctr = CTR_AND;
          3'b110: dec_ctr = CTR_OR;
          3'b010: begin
            // ALU compares unsigned; flipping both sign bits gives a signed compare
            dec_ctr = CTR_SLT;
            dec_op1 = in_rs1 ^ SIGN_FLIP;
            dec_op2 = dec_src2 ^ SIGN_FLIP;
          end
          3'b001, 3'b101: begin
            // the ALU shifts op2, so the shifted value rides on op2
            dec_ctr     = in_funct3[2] ? CTR_SHR : CTR_SHL;
            dec_op1     = '0;
            dec_op2     = in_rs1;
            dec_shamt   = dec_sh_src;
            dec_illegal = dec_sh_bad;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_BR: begin
        dec_ctr     = CTR_SUB;
        dec_op1     = in_rs1;
        dec_op2     = in_rs2;
        dec_is_br   = 1'b1;
        dec_br_ne   = in_funct3[0];
        dec_illegal = (in_funct3[2:1] != 2'b00);
      end
      OPC_LD, OPC_ST: begin
        dec_ctr    = CTR_ADD;
        dec_op1    = in_rs1;
        dec_op2    = in_imm;
        dec_is_mem = 1'b1;
        dec_wen    = (in_opcode == OPC_LD) && (in_rd != 5'd0);
      end
      default: dec_illegal = 1'b1;
    endcase
    // illegal entries carry no operation and no side effects
    if (dec_illegal) begin
      dec_ctr    = CTR_AND;
      dec_op1    = '0;
      dec_op2    = '0;
      dec_shamt  = '0;
      dec_wen    = 1'b0;
      dec_is_br  = 1'b0;
      dec_br_ne  = 1'b0;
      dec_is_mem = 1'b0;
    end
  end

  // ---------------------------------------------------------------- control
  logic        s1_valid_reg;
  logic [3:0]  s1_ctr_reg;
  logic [31:0] s1_op1_reg;
  logic [31:0] s1_op2_reg;
  logic [4:0]  s1_shamt_reg;
  logic [4:0]  s1_rd_reg;
  logic        s1_wen_reg;
  logic        s1_is_br_reg;
  logic        s1_br_ne_reg;
  logic        s1_is_mem_reg;
  logic        s1_illegal_reg;

  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic        head_reg;
  logic        tail_reg;
  logic [ENTRY_W-1:0] q_mem_reg [DEPTH];

  logic        pop;
  logic        push;
  logic        s1_adv;
  logic        accept;
  logic [31:0] push_result;
  logic        push_taken;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign out_valid = rst_n && (count_reg != 2'd0);
  assign pop       = out_valid && out_ready;
  // S1 may hand over its entry when a slot is free or is being freed this cycle
  assign s1_adv    = (count_reg < 2'd2) || pop;
  assign push      = s1_valid_reg && s1_adv;
  assign in_ready  = rst_n && (!s1_valid_reg || s1_adv);
  assign accept    = in_valid && in_ready;

  // ALU is driven only from S1; everything idles at zero when S1 is empty
  assign alu_ctr   = (rst_n && s1_valid_reg) ? s1_ctr_reg   : '0;
  assign alu_op1   = (rst_n && s1_valid_reg) ? s1_op1_reg   : '0;
  assign alu_op2   = (rst_n && s1_valid_reg) ? s1_op2_reg   : '0;
  assign alu_shamt = (rst_n && s1_valid_reg) ? s1_shamt_reg : '0;

  // Shape the ALU answer into a write-back record.
  always_comb begin
    push_result = alu_res;
    if (s1_illegal_reg) begin
      push_result = '0;
    end else if (s1_ctr_reg == CTR_SLT) begin
      push_result = {31'd0, alu_res[0]};
    end
    push_taken = s1_is_br_reg && (alu_zero ^ s1_br_ne_reg);
    push_entry = {push_result, s1_rd_reg, s1_wen_reg, s1_is_br_reg,
                  push_taken, s1_is_mem_reg, s1_illegal_reg};
  end

  // S1 register: load on accept, empty when its entry moves into the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_ctr_reg     <= '0;
      s1_op1_reg     <= '0;
      s1_op2_reg     <= '0;
      s1_shamt_reg   <= '0;
      s1_rd_reg      <= '0;
      s1_wen_reg     <= 1'b0;
      s1_is_br_reg   <= 1'b0;
      s1_br_ne_reg   <= 1'b0;
      s1_is_mem_reg  <= 1'b0;
      s1_illegal_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg   <= 1'b1;
      s1_ctr_reg     <= dec_ctr;
      s1_op1_reg     <= dec_op1;
      s1_op2_reg     <= dec_op2;
      s1_shamt_reg   <= dec_shamt;
      s1_rd_reg      <= in_rd;
      s1_wen_reg     <= dec_wen;
      s1_is_br_reg   <= dec_is_br;
      s1_br_ne_reg   <= dec_br_ne;
      s1_is_mem_reg  <= dec_is_mem;
      s1_illegal_reg <= dec_illegal;
    end else if (s1_adv) begin
      s1_valid_reg   <= 1'b0;
    end
  end

  // Occupancy: a push and pop in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Queue pointers and occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push) tail_reg <= ~tail_reg;
      if (pop)  head_reg <= ~head_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each slot captures the write-back record when the tail points at it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q_mem_reg[gi] <= '0;
        end else if (push && (tail_reg == 1'(gi))) begin
          q_mem_reg[gi] <= push_entry;
        end
      end
    end
  endgenerate

  // Head of queue is presented only while valid; otherwise outputs rest at 0.
  always_comb begin
    head_entry = out_valid ? q_mem_reg[head_reg] : '0;
    {out_result, out_rd, out_wen, out_is_br, out_taken, out_is_mem, out_illegal} = head_entry;
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random checks of alu_issue against a
// RISC-V-level reference model; a behavioural ALU answers the DUT.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_ctr;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_is_br;
  logic        out_taken;
  logic        out_is_mem;
  logic        out_illegal;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        is_br;
    logic        taken;
    logic        is_mem;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   acc;
  int   k;

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctr(alu_ctr), .alu_shamt(alu_shamt),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .out_is_br(out_is_br), .out_taken(out_taken), .out_is_mem(out_is_mem),
    .out_illegal(out_illegal)
  );

  // behavioural combinational ALU the block drives
  always_comb begin
    alu_res = '0;
    case (alu_ctr)
      4'b0000: alu_res = alu_op1 & alu_op2;
      4'b0001: alu_res = alu_op1 | alu_op2;
      4'b0010: alu_res = alu_op1 + alu_op2;
      4'b0011: alu_res = alu_op1 - alu_op2;
      4'b1010: alu_res = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
      4'b1000: alu_res = alu_op2 << alu_shamt;
      4'b1001: alu_res = alu_op2 >> alu_shamt;
      4'b1100: alu_res = alu_op2;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  // reference: architectural outcome of one instruction
  function automatic exp_t ref_model(input logic [6:0] op, input logic [2:0] f3,
                                     input logic b5, input logic [31:0] rs1,
                                     input logic [31:0] rs2, input logic [31:0] imm,
                                     input logic [4:0] rd);
    exp_t e;
    logic ill;
    logic [31:0] b;
    e = '0;
    ill = 1'b0;
    e.rd = rd;
    b = (op == 7'h33) ? rs2 : imm;
    case (op)
      7'h33, 7'h13: begin
        e.wen = (rd != 5'd0);
        case (f3)
          3'd0: e.res = (op == 7'h33 && b5) ? rs1 - b : rs1 + b;
          3'd7: e.res = rs1 & b;
          3'd6: e.res = rs1 | b;
          3'd2: e.res = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
          3'd1: if ((op == 7'h33) ? b5 : imm[10]) ill = 1'b1; else e.res = rs1 << b[4:0];
          3'd5: if ((op == 7'h33) ? b5 : imm[10]) ill = 1'b1; else e.res = rs1 >> b[4:0];
          default: ill = 1'b1;
        endcase
      end
      7'h63: begin
        e.is_br = 1'b1;
        e.res   = rs1 - rs2;
        if (f3 == 3'd0)      e.taken = (rs1 == rs2);
        else if (f3 == 3'd1) e.taken = (rs1 != rs2);
        else                 ill = 1'b1;
      end
      7'h03: begin e.res = rs1 + imm; e.is_mem = 1'b1; e.wen = (rd != 5'd0); end
      7'h23: begin e.res = rs1 + imm; e.is_mem = 1'b1; end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e = '0;
      e.rd = rd;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic b5, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [4:0] rd);
    in_valid = v; in_opcode = op; in_funct3 = f3; in_funct7b5 = b5;
    in_rs1 = r1; in_rs2 = r2; in_imm = im; in_rd = rd;
  endtask

  task automatic idle();
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'h0);
  endtask

  // one clock: check head against model, record accepts, advance to next negedge
  task automatic cyc(output bit accepted);
    exp_t obs;
    #1;
    accepted = 1'b0;
    obs = {out_result, out_rd, out_wen, out_is_br, out_taken, out_is_mem, out_illegal};
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'(1'b0));
      end else begin
        chk(out_ready ? "pop" : "hold", 64'(obs), 64'(q[0]));
        if (out_ready) begin
          $display("[TB] pop rd=%0d res=%h wen=%0b br=%0b tk=%0b mem=%0b ill=%0b",
                   out_rd, out_result, out_wen, out_is_br, out_taken, out_is_mem, out_illegal);
          void'(q.pop_front());
        end
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(ref_model(in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, in_rd));
      accepted = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit a;
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc(a);
    chk("drain_left", 64'(q.size()), 64'd0);
    #1 chk("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  // single instruction with explicit ALU-side and result expectations
  task automatic one(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic b5, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] im, input logic [4:0] rd, input logic [3:0] exp_ctr,
                     input logic [4:0] exp_shamt, input logic [31:0] exp_res,
                     input logic [4:0] exp_flags);
    bit a;
    out_ready = 1'b1;
    drive(1'b1, op, f3, b5, r1, r2, im, rd);
    cyc(a);
    chk({tag, "_accept"}, 64'(a), 64'd1);
    idle();
    #1;
    if (exp_ctr != 4'hF) chk({tag, "_ctr"}, 64'(alu_ctr), 64'(exp_ctr));
    chk({tag, "_shamt"}, 64'(alu_shamt), 64'(exp_shamt));
    chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    cyc(a);
    #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_res"}, 64'(out_result), 64'(exp_res));
    chk({tag, "_rd"}, 64'(out_rd), 64'(rd));
    chk({tag, "_flags"}, 64'({out_wen, out_is_br, out_taken, out_is_mem, out_illegal}),
        64'(exp_flags));
    drain();
  endtask

  task automatic rand_drive();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic [31:0] r1;
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0, 1, 2: op = 7'h33;
      3, 4, 5: op = 7'h13;
      6:       op = 7'h63;
      7:       op = 7'h03;
      8:       op = 7'h23;
      default: op = 7'($urandom_range(0, 127));
    endcase
    f3 = 3'($urandom_range(0, 7));
    if (op == 7'h63 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
    i12 = 12'($urandom_range(0, 4095));
    r1 = $urandom;
    drive(1'($urandom_range(0, 9) < 7), op, f3, 1'($urandom_range(0, 3) == 0), r1,
          ($urandom_range(0, 3) == 0) ? r1 : $urandom, {{20{i12[11]}}, i12},
          5'($urandom_range(0, 31)));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_ctr", 64'(alu_ctr), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_alu_op1", 64'(alu_op1), 64'd0);
    @(negedge clk);

    // directed operations
    one("add",   7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 4'b0010, 5'd0, 32'd12, 5'b10000);
    one("sub",   7'h33, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd4, 4'b0011, 5'd0, 32'hFFFF_FFFE, 5'b10000);
    one("slt",   7'h33, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, 4'b1010, 5'd0, 32'd1, 5'b10000);
    one("slti",  7'h13, 3'd2, 1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 5'd6, 4'b1010, 5'd0, 32'd0, 5'b10000);
    one("sll",   7'h33, 3'd1, 1'b0, 32'd1, 32'h25, 32'd0, 5'd7, 4'b1000, 5'd5, 32'd32, 5'b10000);
    one("srli",  7'h13, 3'd5, 1'b0, 32'h8000_0000, 32'd0, 32'd31, 5'd8, 4'b1001, 5'd31, 32'd1, 5'b10000);
    one("beq",   7'h63, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0, 5'd0, 4'b0011, 5'd0, 32'd0, 5'b01100);
    one("bne",   7'h63, 3'd1, 1'b0, 32'd9, 32'd9, 32'd0, 5'd0, 4'b0011, 5'd0, 32'd0, 5'b01000);
    one("lw",    7'h03, 3'd2, 1'b0, 32'h100, 32'd0, 32'hFFFF_FFFC, 5'd9, 4'b0010, 5'd0, 32'hFC, 5'b10010);
    one("ill",   7'h7F, 3'd0, 1'b0, 32'd5, 32'd6, 32'd7, 5'd10, 4'hF, 5'd0, 32'd0, 5'b00001);
    one("addi0", 7'h13, 3'd0, 1'b0, 32'd5, 32'd0, 32'd3, 5'd0, 4'b0010, 5'd0, 32'd8, 5'b00000);
    one("srai",  7'h13, 3'd5, 1'b0, 32'hF0, 32'd0, 32'h400, 5'd11, 4'hF, 5'd0, 32'd0, 5'b00001);

    // backpressure: queue and S1 fill, head holds still, then drains in order
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 7'h33, 3'd0, 1'b0, 32'(100 * (k + 1)), 32'(k), 32'd0, 5'(k + 1));
      cyc(acc);
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd3);
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head", 64'(out_result), 64'd100);
    cyc(acc);
    cyc(acc);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 4; c++) begin
      drive(1'b1, 7'h33, 3'd0, 1'b0, 32'(100 * (k + 1)), 32'(k), 32'd0, 5'(k + 1));
      cyc(acc);
      if (acc) k++;
    end
    chk("bp_all_accepted", 64'(k), 64'd4);
    drain();

    // reset with full queue and full S1
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 7'h33, 3'd6, 1'b0, 32'(c), 32'h10, 32'd0, 5'd12);
      cyc(acc);
      if (acc) k++;
    end
    chk("rstq_accepted", 64'(k), 64'd3);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rstq_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    #1;
    chk("rstq_out_valid", 64'(out_valid), 64'd0);
    chk("rstq_in_ready_after", 64'(in_ready), 64'd1);
    @(negedge clk);
    one("post_rst", 7'h33, 3'd0, 1'b0, 32'd20, 32'd22, 32'd0, 5'd13, 4'b0010, 5'd0, 32'd42, 5'b10000);

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      rand_drive();
      out_ready = 1'($urandom_range(0, 9) < 6);
      cyc(acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
